// File: rtl/dpc_window_3x3_if.sv
// Stream interface of the 3x3 window builder: raster pixels in, tagged windows out.
// The master drives pixels and observes windows; the slave is the window builder.
interface dpc_window_3x3_if #(
    parameter int DW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic [9*DW-1:0] out_win;
    logic [10:0]     out_row;
    logic [10:0]     out_col;
    logic            out_sof;
    logic            out_eol;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_win, out_row, out_col, out_sof, out_eol
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_win, out_row, out_col, out_sof, out_eol
    );
endinterface

// File: rtl/dpc_window_3x3.sv
// 3x3 neighbourhood builder with clamp padding for the dead-pixel corrector.
// Two circular line buffers addressed by the input column feed three 3-deep column shifters.
module dpc_window_3x3 #(
    parameter int DW         = 16,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 512
) (
    input logic             clk,
    input logic             rst_n,
    dpc_window_3x3_if.slave bus
);

    typedef enum logic [1:0] {ACTIVE, COLFLUSH, ROWFLUSH, ROWCOLFLUSH} state_e;

    localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [10:0] LAST_COL = 11'(IMG_WIDTH - 1);
    localparam logic [11:0] NUM_ROWS = 12'(IMG_HEIGHT);

    state_e          state_q;
    logic            ready_q;
    logic [10:0]     cIn_q;
    logic [11:0]     rIn_q;
    logic [3*DW-1:0] col_q [3];

    logic [DW-1:0]   line1Mem [IMG_WIDTH];
    logic [DW-1:0]   line2Mem [IMG_WIDTH];

    logic            outValid_q, outSof_q, outEol_q;
    logic [9*DW-1:0] outWin_q;
    logic [10:0]     outRow_q, outCol_q;

    logic            accept, adv, lineAdv, dupCol;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   tap0, tap1, tap2, topPix;
    logic [3*DW-1:0] newCol, leftCol;
    logic [3*DW-1:0] colNext [3];
    logic [9*DW-1:0] winNext;
    logic            emit;
    logic [10:0]     emitRow, emitCol;

    assign accept  = bus.in_valid & ready_q;
    assign adv     = accept | (state_q != ACTIVE);
    assign lineAdv = accept | (state_q == ROWFLUSH);
    assign dupCol  = (state_q == COLFLUSH) | (state_q == ROWCOLFLUSH);
    assign addr    = cIn_q[AW-1:0];

    // Buffers hold the previous two rows at the current column; ROWFLUSH recirculates the last row.
    assign tap1   = line1Mem[addr];
    assign tap2   = line2Mem[addr];
    assign tap0   = (state_q == ROWFLUSH) ? tap1 : bus.in_data;
    assign topPix = (rIn_q == 12'd1) ? tap1 : tap2;
    assign newCol = {tap0, tap1, topPix};

    always_ff @(posedge clk) begin
        if (lineAdv) begin
            line1Mem[addr] <= tap0;
            line2Mem[addr] <= tap1;
        end
    end

    always_comb begin
        emit    = 1'b0;
        emitRow = '0;
        emitCol = '0;
        unique case (state_q)
            ACTIVE: begin
                emit    = accept && (rIn_q != 12'd0) && (cIn_q != 11'd0);
                emitRow = 11'(rIn_q - 12'd1);
                emitCol = cIn_q - 11'd1;
            end
            COLFLUSH: begin
                emit    = (rIn_q >= 12'd2);
                emitRow = 11'(rIn_q - 12'd2);
                emitCol = LAST_COL;
            end
            ROWFLUSH: begin
                emit    = (cIn_q != 11'd0);
                emitRow = 11'(rIn_q - 12'd1);
                emitCol = cIn_q - 11'd1;
            end
            ROWCOLFLUSH: begin
                emit    = 1'b1;
                emitRow = 11'(rIn_q - 12'd1);
                emitCol = LAST_COL;
            end
        endcase
    end

    // Column packing is {bottom, middle, top}; flush cycles duplicate the rightmost column.
    always_comb begin
        colNext[0] = col_q[1];
        colNext[1] = col_q[2];
        colNext[2] = dupCol ? col_q[2] : newCol;
        leftCol    = (emitCol == 11'd0) ? colNext[1] : colNext[0];
        winNext    = '0;
        for (int r = 0; r < 3; r++) begin
            winNext[(3*r+0)*DW +: DW] = leftCol[r*DW +: DW];
            winNext[(3*r+1)*DW +: DW] = colNext[1][r*DW +: DW];
            winNext[(3*r+2)*DW +: DW] = colNext[2][r*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACTIVE;
            ready_q <= 1'b0;
            cIn_q   <= '0;
            rIn_q   <= '0;
        end else begin
            unique case (state_q)
                ACTIVE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (cIn_q == LAST_COL) begin
                            cIn_q   <= '0;
                            rIn_q   <= rIn_q + 12'd1;
                            state_q <= COLFLUSH;
                            ready_q <= 1'b0;
                        end else begin
                            cIn_q <= cIn_q + 11'd1;
                        end
                    end
                end
                COLFLUSH: begin
                    if (rIn_q == NUM_ROWS) begin
                        state_q <= ROWFLUSH;
                    end else begin
                        state_q <= ACTIVE;
                        ready_q <= 1'b1;
                    end
                end
                ROWFLUSH: begin
                    if (cIn_q == LAST_COL) begin
                        cIn_q   <= '0;
                        state_q <= ROWCOLFLUSH;
                    end else begin
                        cIn_q <= cIn_q + 11'd1;
                    end
                end
                ROWCOLFLUSH: begin
                    cIn_q   <= '0;
                    rIn_q   <= '0;
                    state_q <= ACTIVE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q[0]   <= '0;
            col_q[1]   <= '0;
            col_q[2]   <= '0;
            outValid_q <= 1'b0;
            outSof_q   <= 1'b0;
            outEol_q   <= 1'b0;
            outWin_q   <= '0;
            outRow_q   <= '0;
            outCol_q   <= '0;
        end else begin
            if (adv) begin
                col_q[0] <= colNext[0];
                col_q[1] <= colNext[1];
                col_q[2] <= colNext[2];
            end
            outValid_q <= emit;
            outSof_q   <= emit && (emitRow == 11'd0) && (emitCol == 11'd0);
            outEol_q   <= emit && (emitCol == LAST_COL);
            if (emit) begin
                outWin_q <= winNext;
                outRow_q <= emitRow;
                outCol_q <= emitCol;
            end
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_win   = outWin_q;
    assign bus.out_row   = outRow_q;
    assign bus.out_col   = outCol_q;
    assign bus.out_sof   = outSof_q;
    assign bus.out_eol   = outEol_q;

endmodule

// File: tb/tb_dpc_window_3x3.sv
// Bench for dpc_window_3x3: a 4x3 frame instance and a 1024x2 boundary instance,
// checked against a clamp-padding window model through expected/observed queues.
module tb_dpc_window_3x3;

    typedef struct packed {
        logic [287:0] win;
        logic [10:0]  row;
        logic [10:0]  col;
        logic         sof;
        logic         eol;
    } winRec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dpc_window_3x3_if #(.DW(16)) sIf ();
    dpc_window_3x3_if #(.DW(32)) bIf ();

    dpc_window_3x3 #(.DW(16), .IMG_WIDTH(4), .IMG_HEIGHT(3)) dutS (
        .clk(clk), .rst_n(rst_n), .bus(sIf)
    );
    dpc_window_3x3 #(.DW(32), .IMG_WIDTH(1024), .IMG_HEIGHT(2)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(bIf)
    );

    int      testCount = 0;
    int      failCount = 0;
    winRec_t expQ [$];
    winRec_t obsS [$];
    winRec_t obsB [$];
    int      waitLog [$];
    winRec_t recS, recB;

    always @(negedge clk) begin
        if (sIf.out_valid === 1'b1) begin
            recS          = '0;
            recS.win[143:0] = sIf.out_win;
            recS.row      = sIf.out_row;
            recS.col      = sIf.out_col;
            recS.sof      = sIf.out_sof;
            recS.eol      = sIf.out_eol;
            obsS.push_back(recS);
        end
        if (bIf.out_valid === 1'b1) begin
            recB     = '0;
            recB.win = bIf.out_win;
            recB.row = bIf.out_row;
            recB.col = bIf.out_col;
            recB.sof = bIf.out_sof;
            recB.eol = bIf.out_eol;
            obsB.push_back(recB);
        end
    end

    function automatic winRec_t modelWin(input int w, input int h, input int r, input int c,
                                         input logic [31:0] base, input logic [31:0] rowMul,
                                         input int dw);
        winRec_t     rec;
        int          rr, cc;
        logic [31:0] p;
        rec = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr < 0) rr = 0;
                if (rr > h - 1) rr = h - 1;
                if (cc < 0) cc = 0;
                if (cc > w - 1) cc = w - 1;
                p = base + rowMul * 32'(rr) + 32'(cc);
                if (dw == 16) rec.win[(dr*3+dc)*16 +: 16] = p[15:0];
                else          rec.win[(dr*3+dc)*32 +: 32] = p;
            end
        end
        rec.row = 11'(r);
        rec.col = 11'(c);
        rec.sof = (r == 0) && (c == 0);
        rec.eol = (c == w - 1);
        return rec;
    endfunction

    task automatic pushFrame(input int w, input int h, input logic [31:0] base,
                             input logic [31:0] rowMul, input int dw);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                expQ.push_back(modelWin(w, h, r, c, base, rowMul, dw));
    endtask

    // Presents one beat (after optional idle gaps) and returns how many cycles in_ready held it off.
    task automatic applyStimulus(input bit big, input logic [31:0] d, input int duty, output int waits);
        if (duty < 100) begin
            while (int'($urandom_range(99)) >= duty) begin
                if (big) bIf.in_valid = 1'b0; else sIf.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        if (big) begin bIf.in_valid = 1'b1; bIf.in_data = d; end
        else begin sIf.in_valid = 1'b1; sIf.in_data = d[15:0]; end
        waits = 0;
        while (!(big ? bIf.in_ready : sIf.in_ready) && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
    endtask

    task automatic sendFrame(input bit big, input int w, input int h, input logic [31:0] base,
                             input logic [31:0] rowMul, input int duty);
        int wt;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                applyStimulus(big, base + rowMul * 32'(r) + 32'(c), duty, wt);
                waitLog.push_back(wt);
            end
    endtask

    task automatic waitObs(input bit big, input int n, input int budget);
        int k = 0;
        while ((big ? obsB.size() : obsS.size()) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        sIf.in_valid = 1'b0; sIf.in_data = '0;
        bIf.in_valid = 1'b0; bIf.in_data = '0;
        #11;
        testCount++;
        if (sIf.in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready got %b required 0", sIf.in_ready); end
        testCount++;
        if (sIf.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got %b required 0", sIf.out_valid); end
        testCount++;
        if (sIf.out_win !== '0) begin failCount++; $display("[TB] FAIL reset_win got %h required 0", sIf.out_win); end
        testCount++;
        if ({sIf.out_row, sIf.out_col, sIf.out_sof, sIf.out_eol} !== 24'd0) begin
            failCount++; $display("[TB] FAIL reset_tags got row %0d col %0d sof %b eol %b required all 0",
                                  sIf.out_row, sIf.out_col, sIf.out_sof, sIf.out_eol);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        testCount++;
        if (sIf.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL post_reset_ready got %b required 1", sIf.in_ready); end
        testCount++;
        if (sIf.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL post_reset_valid got %b required 0", sIf.out_valid); end
    endtask

    task automatic test_directed_frame();
        winRec_t got, exp;
        logic [143:0] lit00, lit12, lit23;
        int expWait;
        lit00 = {16'd11, 16'd10, 16'd10, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0};
        lit12 = {16'd23, 16'd22, 16'd21, 16'd13, 16'd12, 16'd11, 16'd3, 16'd2, 16'd1};
        lit23 = {16'd23, 16'd23, 16'd22, 16'd23, 16'd23, 16'd22, 16'd13, 16'd13, 16'd12};
        obsS.delete(); expQ.delete(); waitLog.delete();
        pushFrame(4, 3, 32'd0, 32'd10, 16);
        sendFrame(1'b0, 4, 3, 32'd0, 32'd10, 100);
        sIf.in_valid = 1'b0;
        waitObs(1'b0, 12, 100);
        for (int i = 0; i < 12; i++) begin
            expWait = ((i % 4) == 0 && i > 0) ? 1 : 0;
            testCount++;
            if (waitLog[i] != expWait) begin
                failCount++; $display("[TB] FAIL directed_ready_gap pixel %0d got %0d required %0d", i, waitLog[i], expWait);
            end
        end
        testCount++;
        if (obsS.size() != 12) begin failCount++; $display("[TB] FAIL directed_count got %0d required 12", obsS.size()); end
        testCount++;
        if (obsS.size() < 12 || obsS[0].win[143:0] !== lit00 || obsS[0].sof !== 1'b1) begin
            failCount++; $display("[TB] FAIL directed_c00 got %h sof %b required %h sof 1", obsS[0].win[143:0], obsS[0].sof, lit00);
        end
        testCount++;
        if (obsS.size() < 12 || obsS[6].win[143:0] !== lit12) begin
            failCount++; $display("[TB] FAIL directed_c12 got %h required %h", obsS[6].win[143:0], lit12);
        end
        testCount++;
        if (obsS.size() < 12 || obsS[11].win[143:0] !== lit23 || obsS[11].eol !== 1'b1) begin
            failCount++; $display("[TB] FAIL directed_c23 got %h eol %b required %h eol 1", obsS[11].win[143:0], obsS[11].eol, lit23);
        end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            if (obsS.size() > 0) got = obsS.pop_front(); else got = '0;
            testCount++;
            if (got !== exp) begin
                failCount++; $display("[TB] FAIL directed_win got r%0d c%0d sof%b eol%b %h required r%0d c%0d sof%b eol%b %h",
                                      got.row, got.col, got.sof, got.eol, got.win, exp.row, exp.col, exp.sof, exp.eol, exp.win);
            end
        end
    endtask

    task automatic test_back_to_back();
        winRec_t got, exp;
        int expWait, lr;
        obsS.delete(); expQ.delete(); waitLog.delete();
        pushFrame(4, 3, 32'd0, 32'd10, 16);
        pushFrame(4, 3, 32'd0, 32'd10, 16);
        sendFrame(1'b0, 4, 3, 32'd0, 32'd10, 100);
        sendFrame(1'b0, 4, 3, 32'd0, 32'd10, 100);
        sIf.in_valid = 1'b0;
        waitObs(1'b0, 24, 200);
        for (int i = 0; i < 24; i++) begin
            lr = (i % 12) / 4;
            expWait = (i == 12) ? 6 : (((i % 4) == 0 && lr > 0) ? 1 : 0);
            testCount++;
            if (waitLog[i] != expWait) begin
                failCount++; $display("[TB] FAIL b2b_ready_gap pixel %0d got %0d required %0d", i, waitLog[i], expWait);
            end
        end
        testCount++;
        if (obsS.size() != 24) begin failCount++; $display("[TB] FAIL b2b_count got %0d required 24", obsS.size()); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            if (obsS.size() > 0) got = obsS.pop_front(); else got = '0;
            testCount++;
            if (got !== exp) begin
                failCount++; $display("[TB] FAIL b2b_win got r%0d c%0d sof%b eol%b %h required r%0d c%0d sof%b eol%b %h",
                                      got.row, got.col, got.sof, got.eol, got.win, exp.row, exp.col, exp.sof, exp.eol, exp.win);
            end
        end
    endtask

    task automatic test_gaps();
        winRec_t got, exp;
        obsS.delete(); expQ.delete(); waitLog.delete();
        pushFrame(4, 3, 32'd0, 32'd10, 16);
        sendFrame(1'b0, 4, 3, 32'd0, 32'd10, 60);
        sIf.in_valid = 1'b0;
        waitObs(1'b0, 12, 200);
        testCount++;
        if (obsS.size() != 12) begin failCount++; $display("[TB] FAIL gaps_count got %0d required 12", obsS.size()); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            if (obsS.size() > 0) got = obsS.pop_front(); else got = '0;
            testCount++;
            if (got !== exp) begin
                failCount++; $display("[TB] FAIL gaps_win got r%0d c%0d %h required r%0d c%0d %h",
                                      got.row, got.col, got.win, exp.row, exp.col, exp.win);
            end
        end
    endtask

    task automatic test_reset_midframe();
        winRec_t got, exp;
        int wt;
        obsS.delete(); expQ.delete(); waitLog.delete();
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b0, 32'(10 * (i / 4) + (i % 4)), 100, wt);
        sIf.in_valid = 1'b0;
        testCount++;
        if (sIf.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL midreset_pre_valid got %b required 1", sIf.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        testCount++;
        if (sIf.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_valid got %b required 0", sIf.out_valid); end
        testCount++;
        if (sIf.out_win !== '0) begin failCount++; $display("[TB] FAIL midreset_win got %h required 0", sIf.out_win); end
        testCount++;
        if ({sIf.out_row, sIf.out_col, sIf.out_sof, sIf.out_eol} !== 24'd0) begin
            failCount++; $display("[TB] FAIL midreset_tags got row %0d col %0d required 0 0", sIf.out_row, sIf.out_col);
        end
        testCount++;
        if (sIf.in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_ready got %b required 0", sIf.in_ready); end
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        testCount++;
        if (sIf.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_release_valid got %b required 0", sIf.out_valid); end
        obsS.delete();
        pushFrame(4, 3, 32'd0, 32'd10, 16);
        sendFrame(1'b0, 4, 3, 32'd0, 32'd10, 100);
        sIf.in_valid = 1'b0;
        waitObs(1'b0, 12, 100);
        testCount++;
        if (obsS.size() != 12) begin failCount++; $display("[TB] FAIL midreset_count got %0d required 12", obsS.size()); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            if (obsS.size() > 0) got = obsS.pop_front(); else got = '0;
            testCount++;
            if (got !== exp) begin
                failCount++; $display("[TB] FAIL midreset_win got r%0d c%0d sof%b %h required r%0d c%0d sof%b %h",
                                      got.row, got.col, got.sof, got.win, exp.row, exp.col, exp.sof, exp.win);
            end
        end
    endtask

    task automatic test_boundary();
        winRec_t got, exp;
        int maxCol;
        obsB.delete(); expQ.delete(); waitLog.delete();
        pushFrame(1024, 2, 32'hA500_0000, 32'h0001_0000, 32);
        sendFrame(1'b1, 1024, 2, 32'hA500_0000, 32'h0001_0000, 100);
        bIf.in_valid = 1'b0;
        waitObs(1'b1, 2048, 6000);
        testCount++;
        if (obsB.size() != 2048) begin failCount++; $display("[TB] FAIL boundary_count got %0d required 2048", obsB.size()); end
        maxCol = 0;
        foreach (obsB[i]) if (int'(obsB[i].col) > maxCol) maxCol = int'(obsB[i].col);
        testCount++;
        if (maxCol != 1023) begin failCount++; $display("[TB] FAIL boundary_maxcol got %0d required 1023", maxCol); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            if (obsB.size() > 0) got = obsB.pop_front(); else got = '0;
            testCount++;
            if (got !== exp) begin
                failCount++; $display("[TB] FAIL boundary_win got r%0d c%0d eol%b %h required r%0d c%0d eol%b %h",
                                      got.row, got.col, got.eol, got.win, exp.row, exp.col, exp.eol, exp.win);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_frame();
        test_back_to_back();
        test_gaps();
        test_reset_midframe();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
